// File: rtl/sdp_cq_ram_128x14.sv
// 128x14 register-file RAM behind the SDP MRDMA command-queue FIFO.
// Two-stage read: re latches the address, ore loads array data into dout.
module sdp_cq_ram_128x14 #(
  parameter logic FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b0,
  parameter int   DEPTH = 128,
  parameter int   WIDTH = 14,
  parameter int   AW    = 7
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic [31:0]      pwrbus_ram_pd,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ra_d;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] dout_q;

  // Power-down bus has no functional effect on this model.
  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  // Array is deliberately not reset so contents survive a mid-run reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (we) mem[wa] <= di;
`ifndef SYNTHESIS
    else if ($isunknown(we)) mem[wa] <= 'x;
`endif
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) ra_d <= '0;
    else if (re) ra_d <= ra;
`ifndef SYNTHESIS
    else if ($isunknown(re)) ra_d <= 'x;
`endif
  end

  assign rd_data = mem[ra_d];

  // ore samples the pre-edge ra_d, so re and ore together stream one word per cycle.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) dout_q <= '0;
    else if (ore) dout_q <= rd_data;
`ifndef SYNTHESIS
    else if ($isunknown(ore)) dout_q <= 'x;
`endif
  end

  assign dout = dout_q;

`ifndef SYNTHESIS
  always @(posedge nvdla_core_clk) begin
    if (!FORCE_CONTENTION_ASSERTION_RESET_ACTIVE && !nvdla_core_rst &&
        we && ore && (wa == ra_d))
      $display("%m: warning: read/write contention at address %0d", wa);
  end
`endif

endmodule

// File: tb/tb_sdp_cq_ram_128x14.sv
// Directed bench for sdp_cq_ram_128x14: reset, latency, streaming, hold, same-address cases.
module tb_sdp_cq_ram_128x14;
  localparam int W  = 14;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pd;
  logic [AW-1:0] wa, ra;
  logic          we, re, ore;
  logic [W-1:0]  di;
  logic [W-1:0]  dout;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sdp_cq_ram_128x14 dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .pwrbus_ram_pd  (pd),
    .wa             (wa),
    .we             (we),
    .di             (di),
    .ra             (ra),
    .re             (re),
    .ore            (ore),
    .dout           (dout)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; ore = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pd = '0; wa = '0; ra = '0; di = '0;
    idle();
    tick(); tick();
    checks++;
    if (dout !== 14'h0) begin errs++; $display("FAIL reset_dout: got %h want %h", dout, 14'h0); end
    rst = 1'b0;
    tick();
    checks++;
    if (dout !== 14'h0) begin errs++; $display("FAIL post_reset_dout: got %h want %h", dout, 14'h0); end
  endtask

  task automatic test_basic();
    we = 1'b1; wa = 7'd5; di = 14'h1A5;
    tick();
    we = 1'b0; re = 1'b1; ra = 7'd5;
    tick();
    checks++;
    if (dout !== 14'h0) begin errs++; $display("FAIL basic_early: got %h want %h", dout, 14'h0); end
    re = 1'b0; ore = 1'b1;
    tick();
    ore = 1'b0;
    checks++;
    if (dout !== 14'h1A5) begin errs++; $display("FAIL basic_read: got %h want %h", dout, 14'h1A5); end
    tick(); tick();
    checks++;
    if (dout !== 14'h1A5) begin errs++; $display("FAIL basic_hold: got %h want %h", dout, 14'h1A5); end
  endtask

  task automatic test_same_addr();
    we = 1'b1; wa = 7'd9; di = 14'h3FFF; re = 1'b1; ra = 7'd9;
    tick();
    we = 1'b0; re = 1'b0; ore = 1'b1;
    tick();
    ore = 1'b0;
    checks++;
    if (dout !== 14'h3FFF) begin errs++; $display("FAIL same_addr: got %h want %h", dout, 14'h3FFF); end
  endtask

  task automatic test_hold();
    we = 1'b1; wa = 7'd3; di = 14'h0123;
    tick();
    we = 1'b0; re = 1'b1; ra = 7'd3;
    tick();
    re = 1'b0;
    for (int k = 0; k < 4; k++) begin
      we = 1'b1; wa = 7'(10 + k); di = 14'(14'h0F00 + k);
      tick();
      checks++;
      if (dout !== 14'h3FFF) begin errs++; $display("FAIL hold_cycle%0d: got %h want %h", k, dout, 14'h3FFF); end
    end
    we = 1'b0; ore = 1'b1;
    tick();
    ore = 1'b0;
    checks++;
    if (dout !== 14'h0123) begin errs++; $display("FAIL hold_release: got %h want %h", dout, 14'h0123); end
  endtask

  // Fill then stream re/ore every cycle, wrapping 127 -> 0; pwrbus toggles mid-stream.
  task automatic test_back_to_back();
    logic [W-1:0] exp;
    for (int i = 0; i < 128; i++) begin
      we = 1'b1; wa = 7'(i); di = 14'(i) ^ 14'h2AA;
      tick();
    end
    we = 1'b0;
    for (int k = 0; k <= 129; k++) begin
      if (k == 64) pd = 32'hFFFF_FFFF;
      if (k == 96) pd = 32'h0;
      re  = (k <= 128);
      ra  = 7'(k % 128);
      ore = (k >= 1);
      tick();
      if (k >= 1) begin
        exp = 14'((k - 1) % 128) ^ 14'h2AA;
        checks++;
        if (dout !== exp) begin errs++; $display("FAIL stream_k%0d: got %h want %h", k, dout, exp); end
      end
    end
    idle();
    pd = '0;
  endtask

  task automatic test_reset_mid();
    we = 1'b1; wa = 7'd20; di = 14'h1234;
    tick();
    we = 1'b0; re = 1'b1; ra = 7'd20;
    tick();
    re = 1'b0; ore = 1'b1;
    tick();
    checks++;
    if (dout !== 14'h1234) begin errs++; $display("FAIL pre_reset_read: got %h want %h", dout, 14'h1234); end
    rst = 1'b1;
    #1;
    checks++;
    if (dout !== 14'h0) begin errs++; $display("FAIL reset_async: got %h want %h", dout, 14'h0); end
    tick();
    checks++;
    if (dout !== 14'h0) begin errs++; $display("FAIL reset_hold_ore: got %h want %h", dout, 14'h0); end
    rst = 1'b0;
    tick();
    ore = 1'b0;
    // ra_d cleared by reset, so this ore reads address 0.
    checks++;
    if (dout !== 14'h2AA) begin errs++; $display("FAIL reset_ra_d_zero: got %h want %h", dout, 14'h2AA); end
    re = 1'b1; ra = 7'd20;
    tick();
    re = 1'b0; ore = 1'b1;
    tick();
    ore = 1'b0;
    checks++;
    if (dout !== 14'h1234) begin errs++; $display("FAIL reset_retained: got %h want %h", dout, 14'h1234); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_addr();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
